// File: rtl/div_unit_pkg.sv
// div_unit shared types and constants.
// Op encoding, FSM states and datapath sizes.
package div_unit_pkg;

   localparam int XLEN      = 32;
   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = $clog2(DIV_ITERS);

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } div_state_t;

   function automatic logic is_signed_op(div_op_t op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_rem_op(div_op_t op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit EX-stage bundle.
// Master drives the request, slave returns status/result.
interface div_unit_if;
   import div_unit_pkg::*;

   logic            div_en_e;
   logic [1:0]      div_op_e;
   logic [XLEN-1:0] src_a_e;
   logic [XLEN-1:0] src_b_e;
   logic            kill;
   logic            div_done_e;
   logic            div_busy;
   logic [XLEN-1:0] div_result;

   modport master (
      output div_en_e, div_op_e, src_a_e, src_b_e, kill,
      input  div_done_e, div_busy, div_result
   );

   modport slave (
      input  div_en_e, div_op_e, src_a_e, src_b_e, kill,
      output div_done_e, div_busy, div_result
   );

endinterface

// File: rtl/div_unit_step.sv
// div_step: one restoring radix-2 iteration.
// Shifts the next dividend bit into the partial remainder.
module div_step
   import div_unit_pkg::*;
(
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // Trial subtract; keep it only if it did not go negative.
   always_comb begin
      shifted = {rem_i, quo_i[XLEN-1]};
      diff    = shifted - {1'b0, dvs_i};
      if (!diff[XLEN]) begin
         rem_o = diff[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b1};
      end else begin
         rem_o = shifted[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit RISC-V divider.
// Special cases finish in one cycle, others take 32 steps.
module div_unit
   import div_unit_pkg::*;
(
   input logic       clk,
   input logic       rst,
   div_unit_if.slave bus
);

   div_state_t      state_q, state_d;
   div_op_t         op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic [XLEN-1:0] res_q, res_d;

   div_op_t         op_in;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_abs, b_abs;
   logic            b_zero, ovf;
   logic [XLEN-1:0] step_rem, step_quo;

   div_step u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   // Operand signs, magnitudes and special-case detection.
   always_comb begin
      op_in  = div_op_t'(bus.div_op_e);
      a_neg  = is_signed_op(op_in) && bus.src_a_e[XLEN-1];
      b_neg  = is_signed_op(op_in) && bus.src_b_e[XLEN-1];
      a_abs  = a_neg ? -bus.src_a_e : bus.src_a_e;
      b_abs  = b_neg ? -bus.src_b_e : bus.src_b_e;
      b_zero = (bus.src_b_e == '0);
      ovf    = is_signed_op(op_in)
               && (bus.src_a_e == 32'h8000_0000)
               && (bus.src_b_e == 32'hFFFF_FFFF);
   end

   // Next-state, datapath and result selection.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      res_d   = res_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.div_en_e && !bus.kill) begin
               op_d = op_in;
               if (b_zero) begin
                  res_d   = is_rem_op(op_in) ? bus.src_a_e : '1;
                  state_d = S_DONE;
               end else if (ovf) begin
                  res_d   = is_rem_op(op_in) ? '0 : 32'h8000_0000;
                  state_d = S_DONE;
               end else begin
                  quo_d   = a_abs;
                  rem_d   = '0;
                  dvs_d   = b_abs;
                  qneg_d  = a_neg ^ b_neg;
                  rneg_d  = a_neg;
                  cnt_d   = '0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (bus.kill) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               quo_d = step_quo;
               rem_d = step_rem;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
                  if (is_rem_op(op_q))
                     res_d = rneg_q ? -step_rem : step_rem;
                  else
                     res_d = qneg_q ? -step_quo : step_quo;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_DIV;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         res_q   <= res_d;
      end
   end

   // A flushed instruction never reports completion.
   always_comb begin
      bus.div_done_e = (state_q == S_DONE) && !bus.kill;
      bus.div_busy   = (state_q == S_CALC);
      bus.div_result = res_q;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 The port `clk` SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port `rst` SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 The port `div_en_e` SHALL be an input, 1 bit wide: the EX-stage instruction is a divide/remainder.
REQ-005 The port `div_op_e` SHALL be an input, 2 bits wide, encoded 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 The port `src_a_e` SHALL be an input, 32 bits wide: the dividend, already forwarded.
REQ-007 The port `src_b_e` SHALL be an input, 32 bits wide: the divisor, already forwarded.
REQ-008 The port `kill` SHALL be an input, 1 bit wide: the EX instruction is being flushed; abort the operation.
REQ-009 The port `div_done_e` SHALL be an output, 1 bit wide: the result is valid this cycle; the stall releases.
REQ-010 The port `div_busy` SHALL be an output, 1 bit wide: high while an operation is in progress.
REQ-011 The port `div_result` SHALL be an output, 32 bits wide: the quotient or remainder per `div_op_e`.

Function
REQ-012 The block SHALL use a three-state FSM: IDLE, CALC and DONE.
REQ-013 In IDLE with `div_en_e`=1 and `kill`=0, the block SHALL latch the operands and op, and select the next state:
- divisor = 0: go to DONE;
- signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): go to DONE;
- otherwise: go to CALC with the iteration counter = 0.
REQ-014 CALC SHALL perform one restoring radix-2 step per cycle on absolute values for signed ops, run 32 iterations (counter 0..31), and go to DONE when the counter reaches 31.
REQ-015 Latency SHALL be measured from the accept edge at the end of cycle N:
- normal operation: `div_done_e`=1 in cycle N+33;
- special cases: `div_done_e`=1 in cycle N+1.
REQ-016 `div_done_e` SHALL be high for exactly one cycle, in DONE only, and DONE SHALL always go to IDLE.
REQ-017 `div_en_e` SHALL be sampled only in IDLE; a new operation SHALL NOT start in the DONE cycle.
REQ-018 A back-to-back divide SHALL be accepted in the IDLE cycle following DONE.
REQ-019 Divide-by-zero results SHALL be: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = the dividend.
REQ-020 Overflow results SHALL be: DIV = 0x80000000; REM = 0.
REQ-021 Signed sign fixup SHALL be: quotient negated if the operand signs differ; remainder takes the dividend's sign.
REQ-022 `div_result` SHALL be registered, valid and stable during the DONE cycle, and unchanged otherwise.
REQ-023 `kill`=1 in CALC or DONE SHALL force IDLE on the next edge with no `div_done_e`; `kill` SHALL take priority over a simultaneous start.
REQ-024 `div_busy` SHALL be 1 in CALC and 0 in IDLE and DONE.

Reset
REQ-025 `rst`=1 SHALL force IDLE, counter = 0, `div_done_e`=0, `div_busy`=0 and `div_result`=0 on the next edge, including mid-CALC; no `div_done_e` SHALL follow a reset.
REQ-026 Reset SHALL take priority over `kill` and `div_en_e`.

Structure
REQ-027 The shared package SHALL hold the op encoding enum `div_op_t`, the FSM state enum `div_state_t`, and the constants XLEN=32 and DIV_ITERS=32.
REQ-028 One combinational sub-module, `div_step` (a single shift/subtract/restore iteration), SHALL be instantiated once.
REQ-029 Sign handling, special-case detection and the FSM SHALL live in `div_unit`.

Verification
REQ-030 The bench SHALL cover DIVU 100/7: accept in cycle 0 -> `div_done_e` in cycle 33 with result 14; REMU of the same operands -> 2.
REQ-031 The bench SHALL cover DIV -7/2 -> -3 (0xFFFFFFFD) and REM -7/2 -> -1 (0xFFFFFFFF), each with 33-cycle latency.
REQ-032 The bench SHALL cover DIV 5/0 -> 0xFFFFFFFF, and REMU 5/0 -> 5, with done in cycle 1.
REQ-033 The bench SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM of the same operands -> 0, with done in cycle 1.
REQ-034 The bench SHALL cover `kill` at CALC iteration 10 -> IDLE next cycle, with no done pulse; a new DIVU 9/3 then returns 3 after 33 cycles.
REQ-035 The bench SHALL cover `rst` mid-CALC -> all outputs 0 next cycle and no done pulse; plus back-to-back DIVU 8/2 then 9/3 -> results 4 and 3, with the second accepted the cycle after the first's done.
